// File: rtl/flow_ctrl_if.sv
// Config/status bundle between the test/config port, flow_ctrl_fsm and the FIFO bank.
interface flow_ctrl_if #(
    parameter int NUM_CH = 8,
    parameter int TH_W   = 3
);
    logic              init;
    logic [TH_W-1:0]   umbral_bajo_in;
    logic [TH_W-1:0]   umbral_alto_in;
    logic [NUM_CH-1:0] empty_fifos;
    logic [2:0]        state;
    logic [2:0]        next_state;
    logic [TH_W-1:0]   umbral_bajo;
    logic [TH_W-1:0]   umbral_alto;
    logic              idle;
    logic              active;
    logic              error;

    modport master (
        output init, umbral_bajo_in, umbral_alto_in, empty_fifos,
        input  state, next_state, umbral_bajo, umbral_alto,
        input  idle, active, error
    );

    modport slave (
        input  init, umbral_bajo_in, umbral_alto_in, empty_fifos,
        output state, next_state, umbral_bajo, umbral_alto,
        output idle, active, error
    );
endinterface

// File: rtl/flow_ctrl_fsm.sv
// FIFO flow-control FSM: threshold latch, idle/active status, idle-hold filter.
// Optional macro THRESH_CHECK_EN: bajo >= alto on INIT exit goes to ERROR.
module flow_ctrl_fsm #(
    parameter int NUM_CH    = 8,
    parameter int TH_W      = 3,
    parameter int IDLE_HOLD = 1
) (
    input  logic        clk,
    input  logic        reset,
    flow_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_e;

    localparam logic [7:0] HOLD_N = 8'(IDLE_HOLD);

    state_e          state_q, state_d;
    logic [7:0]      hold_q, hold_d;
    logic [7:0]      hold_inc;
    logic [TH_W-1:0] bajo_q, alto_q;
    logic            idle_q, active_q;
    logic            all_empty;
    logic            th_bad;

    assign all_empty = &bus.empty_fifos;
    assign hold_inc  = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;

`ifdef THRESH_CHECK_EN
    logic error_q;
    assign th_bad    = (bajo_q >= alto_q);
    assign bus.error = error_q;
`else
    assign th_bad    = 1'b0;
    assign bus.error = 1'b0;
`endif

    always_comb begin
        state_d = S_RESET;
        hold_d  = '0;
        if (!reset) begin
            case (state_q)
                S_RESET: state_d = S_INIT;
                S_INIT: begin
                    if (bus.init)    state_d = S_INIT;
                    else if (th_bad) state_d = S_ERROR;
                    else             state_d = S_IDLE;
                end
                S_IDLE: begin
                    if (bus.init)        state_d = S_INIT;
                    else if (!all_empty) state_d = S_ACTIVE;
                    else                 state_d = S_IDLE;
                end
                S_ACTIVE: begin
                    if (bus.init) begin
                        state_d = S_INIT;
                    end else if (all_empty) begin
                        // this cycle completes the run of empty cycles?
                        if (hold_inc >= HOLD_N) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_ACTIVE;
                            hold_d  = hold_inc;
                        end
                    end else begin
                        state_d = S_ACTIVE;
                    end
                end
                S_ERROR: begin
                    if (bus.init) state_d = S_INIT;
                    else          state_d = S_ERROR;
                end
                default: state_d = S_RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RESET;
            hold_q   <= '0;
            bajo_q   <= '0;
            alto_q   <= '0;
            idle_q   <= 1'b0;
            active_q <= 1'b0;
`ifdef THRESH_CHECK_EN
            error_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            if (state_q == S_INIT && bus.init) begin
                bajo_q <= bus.umbral_bajo_in;
                alto_q <= bus.umbral_alto_in;
            end
            idle_q   <= (state_d == S_IDLE);
            active_q <= (state_d == S_ACTIVE);
`ifdef THRESH_CHECK_EN
            error_q  <= (state_d == S_ERROR);
`endif
        end
    end

    assign bus.state       = state_q;
    assign bus.next_state  = state_d;
    assign bus.umbral_bajo = bajo_q;
    assign bus.umbral_alto = alto_q;
    assign bus.idle        = idle_q;
    assign bus.active      = active_q;
endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Directed bench for flow_ctrl_fsm with an expected-result queue.
module tb_flow_ctrl_fsm;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   errors;

`ifdef THRESH_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        string      tag;
        bit         which;
        logic [21:0] exp;
    } exp_t;

    exp_t sbq[$];

    flow_ctrl_if #(.NUM_CH(8), .TH_W(3)) bus_a ();
    flow_ctrl_if #(.NUM_CH(4), .TH_W(5)) bus_b ();

    flow_ctrl_fsm #(.NUM_CH(8), .TH_W(3), .IDLE_HOLD(3)) u_a (
        .clk(clk), .reset(rst_a), .bus(bus_a.slave)
    );

    flow_ctrl_fsm #(.NUM_CH(4), .TH_W(5), .IDLE_HOLD(1)) u_b (
        .clk(clk), .reset(rst_b), .bus(bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] pack(int st, bit i, bit a, bit e, int lo, int hi);
        return {st[2:0], i, a, e, lo[7:0], hi[7:0]};
    endfunction

    function automatic logic [21:0] obs(bit which);
        if (which)
            return {bus_b.state, bus_b.idle, bus_b.active, bus_b.error,
                    8'(bus_b.umbral_bajo), 8'(bus_b.umbral_alto)};
        return {bus_a.state, bus_a.idle, bus_a.active, bus_a.error,
                8'(bus_a.umbral_bajo), 8'(bus_a.umbral_alto)};
    endfunction

    task automatic pop_check();
        exp_t       e;
        logic [21:0] got;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_empty got=none want=entry");
            return;
        end
        e   = sbq.pop_front();
        got = obs(e.which);
        assert (got === e.exp) else begin
            errors++;
            $error("FAIL %s got=%h want=%h", e.tag, got, e.exp);
        end
    endtask

    task automatic step_a(bit r, bit in, int lo, int hi, logic [7:0] emp,
                          string tag, int st, bit i, bit a, bit e,
                          int elo, int ehi);
        exp_t x;
        rst_a                = r;
        bus_a.init           = in;
        bus_a.umbral_bajo_in = lo[2:0];
        bus_a.umbral_alto_in = hi[2:0];
        bus_a.empty_fifos    = emp;
        x.tag   = tag;
        x.which = 1'b0;
        x.exp   = pack(st, i, a, e, elo, ehi);
        sbq.push_back(x);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic step_b(bit r, bit in, int lo, int hi, logic [3:0] emp,
                          string tag, int st, bit i, bit a, int elo, int ehi);
        exp_t x;
        rst_b                = r;
        bus_b.init           = in;
        bus_b.umbral_bajo_in = lo[4:0];
        bus_b.umbral_alto_in = hi[4:0];
        bus_b.empty_fifos    = emp;
        x.tag   = tag;
        x.which = 1'b1;
        x.exp   = pack(st, i, a, 1'b0, elo, ehi);
        sbq.push_back(x);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_b  = 1'b1;
        bus_b.init = 1'b0;
        bus_b.umbral_bajo_in = '0;
        bus_b.umbral_alto_in = '0;
        bus_b.empty_fifos = '1;

        for (int k = 0; k < 3; k++)
            step_a(1, 0, 0, 0, 8'hFF, "rst", 0, 0, 0, 0, 0, 0);

        rst_a = 1'b0;
        #1;
        checks++;
        assert (bus_a.next_state === 3'd1) else begin
            errors++;
            $error("FAIL rel_next got=%0d want=1", bus_a.next_state);
        end

        step_a(0, 0, 0, 0, 8'hFF, "to_init", 1, 0, 0, 0, 0, 0);
        step_a(0, 1, 2, 5, 8'hFF, "cap1", 1, 0, 0, 0, 2, 5);
        step_a(0, 1, 2, 5, 8'hFF, "cap2", 1, 0, 0, 0, 2, 5);
        step_a(0, 0, 7, 7, 8'hFF, "to_idle", 2, 1, 0, 0, 2, 5);
        step_a(0, 0, 0, 0, 8'hFF, "idle_stay", 2, 1, 0, 0, 2, 5);
        step_a(0, 0, 0, 0, 8'hFE, "to_act", 3, 0, 1, 0, 2, 5);
        step_a(0, 0, 0, 0, 8'hFF, "hold1", 3, 0, 1, 0, 2, 5);
        step_a(0, 0, 0, 0, 8'hFF, "hold2", 3, 0, 1, 0, 2, 5);
        step_a(0, 0, 0, 0, 8'hF7, "hold_clr", 3, 0, 1, 0, 2, 5);
        step_a(0, 0, 0, 0, 8'hFF, "hold1b", 3, 0, 1, 0, 2, 5);
        step_a(0, 0, 0, 0, 8'hFF, "hold2b", 3, 0, 1, 0, 2, 5);
        step_a(0, 0, 0, 0, 8'hFF, "hold_done", 2, 1, 0, 0, 2, 5);

        step_a(0, 1, 6, 4, 8'hFF, "re_init", 1, 0, 0, 0, 2, 5);
        step_a(0, 1, 6, 4, 8'hFF, "cap_bad", 1, 0, 0, 0, 6, 4);
        step_a(0, 0, 0, 0, 8'hFF, "chk_exit", CHK ? 4 : 2, !CHK, 0, CHK, 6, 4);
        step_a(0, 0, 0, 0, 8'hFF, "chk_hold", CHK ? 4 : 2, !CHK, 0, CHK, 6, 4);
        step_a(0, 1, 1, 6, 8'hFF, "err_init", 1, 0, 0, 0, 6, 4);
        step_a(0, 1, 1, 6, 8'hFF, "cap_ok", 1, 0, 0, 0, 1, 6);
        step_a(0, 0, 0, 0, 8'hFF, "ok_exit", 2, 1, 0, 0, 1, 6);

        step_a(0, 0, 0, 0, 8'h7F, "act2", 3, 0, 1, 0, 1, 6);
        step_a(1, 1, 3, 3, 8'h7F, "rst_init", 0, 0, 0, 0, 0, 0);
        step_a(0, 0, 0, 0, 8'hFF, "rst_rel", 1, 0, 0, 0, 0, 0);

        step_b(1, 0, 0, 0, 4'hF, "b_rst", 0, 0, 0, 0, 0);
        step_b(0, 0, 0, 0, 4'hF, "b_init", 1, 0, 0, 0, 0);
        step_b(0, 1, 17, 30, 4'hF, "b_cap", 1, 0, 0, 17, 30);
        step_b(0, 0, 0, 0, 4'hF, "b_idle", 2, 1, 0, 17, 30);
        step_b(0, 0, 0, 0, 4'hE, "b_act", 3, 0, 1, 17, 30);
        step_b(0, 0, 0, 0, 4'hF, "b_legacy", 2, 1, 0, 17, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/flow_ctrl_fsm.md
# flow_ctrl_fsm

Parametrised control state machine for the FIFO flow-control path. Holds the low/high threshold registers programmed during initialisation and reports idle/active status from the per-channel FIFO empty flags. Adds a configurable channel count, threshold width, an idle-hold filter and an optional threshold-validity check with an error state. Sits between the test/config interface and the FIFO bank; downstream logic consumes the latched thresholds and the status flags.

## Interface
- NUM_CH, 8, number of FIFO channels monitored (1..32)
- TH_W, 3, threshold width in bits (1..8)
- IDLE_HOLD, 1, consecutive all-empty cycles in ACTIVE required before entering IDLE (1..255)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high; overrides every other input
- init  in  1  initialisation request; thresholds captured while high
- umbral_bajo_in  in  TH_W  low threshold to program
- umbral_alto_in  in  TH_W  high threshold to program
- empty_fifos  in  NUM_CH  per-channel FIFO empty flags, bit i = channel i
- state  out  3  current state register
- next_state  out  3  combinational next state
- umbral_bajo  out  TH_W  latched low threshold
- umbral_alto  out  TH_W  latched high threshold
- idle  out  1  registered, high exactly while state = IDLE
- active  out  1  registered, high exactly while state = ACTIVE
- error  out  1  registered, high exactly while state = ERROR

## Operation
- Encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; codes 5-7 -> next_state RESET.
- Reset values: state RESET, umbral_bajo 0, umbral_alto 0, idle/active/error 0, hold counter 0.
- RESET -> INIT unconditionally on first cycle with reset low.
- INIT: while init=1, umbral_bajo/alto load inputs each cycle; stay. When init=0: -> IDLE (or ERROR, see Configuration). Thresholds hold outside INIT; INIT entered with init=0 keeps prior values.
- all_empty = &empty_fifos.
- IDLE: init=1 -> INIT; else !all_empty -> ACTIVE; else stay.
- ACTIVE: init=1 -> INIT; else all_empty for IDLE_HOLD consecutive cycles -> IDLE; else stay. Hold counter (8 bit, saturating) increments on all_empty in ACTIVE, clears on any non-empty cycle and on every exit from ACTIVE.
- ERROR: init=1 -> INIT; else stay.
- Priority everywhere: reset > init > empty-flag conditions.

## Timing
- State register updates on the edge following the sampled condition; one-cycle latency input -> state.
- idle/active/error registered from next_state, so they change in the same cycle as state.
- Threshold capture: value present with init=1 at edge N visible on outputs after edge N.
- IDLE_HOLD=1: ACTIVE -> IDLE on the first all-empty cycle (legacy behaviour).
- Channel going non-empty on the exact cycle the counter would reach IDLE_HOLD: stay ACTIVE, counter cleared.
- reset mid-operation: next edge forces RESET and all reset values including thresholds.

## Configuration
- THRESH_CHECK_EN defined: on INIT exit (init=0), if latched umbral_bajo >= umbral_alto go to ERROR instead of IDLE; ERROR left only via init or reset.
- Not defined: ERROR unreachable, INIT always exits to IDLE, error tied 0, no comparator synthesised.

## Test plan
- reset 3 cycles, release -> state RESET then INIT next cycle; all outputs 0.
- init=1 with bajo=2, alto=5 for 2 cycles, then init=0, empty_fifos=8'hFF -> umbral 2/5, state IDLE, idle=1.
- From IDLE, empty_fifos=8'hFE one cycle -> ACTIVE next edge, active=1; with IDLE_HOLD=3 and 8'hFF for 2 cycles, 8'hF7 once, then 8'hFF 3 cycles -> IDLE only after the final 3rd empty cycle.
- THRESH_CHECK_EN, init with bajo=6, alto=4 -> ERROR, error=1; init=1 with bajo=1, alto=6 -> INIT, then IDLE; without macro same stimulus -> IDLE, error=0.
- In ACTIVE, assert init and reset together -> RESET, thresholds 0.
- NUM_CH=4, TH_W=5: bajo=17, alto=30 latched; empty_fifos=4'hF -> IDLE.
